// File: rtl/regbank_bist_if.sv
// rtl/regbank_bist_if.sv - register bank write/read port bundle between BIST engine and bank
interface regbank_bist_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [AW-1:0] dr;
    logic [DW-1:0] wrdata;
    logic          write;
    logic [AW-1:0] sr1;
    logic [AW-1:0] sr2;
    logic [DW-1:0] rdData1;
    logic [DW-1:0] rdData2;

    modport master (
        output dr, wrdata, write, sr1, sr2,
        input  rdData1, rdData2
    );

    modport slave (
        input  dr, wrdata, write, sr1, sr2,
        output rdData1, rdData2
    );
endinterface

// File: rtl/regbank_bist.sv
// rtl/regbank_bist.sv - register bank BIST: writes step*k to every register, reads back in pairs
// Optional REGBANK_BIST_INV_PASS_EN adds a second pass with the inverted pattern.
module regbank_bist #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DW-1:0]        step,
    regbank_bist_if.master       bank,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           err_count,
    output logic [AW-1:0]        fail_addr
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

    localparam logic [AW-1:0] LAST = '1;

    state_t        state;
    logic [DW-1:0] step_q;
    logic [DW-1:0] p1;
`ifdef REGBANK_BIST_INV_PASS_EN
    logic          inv;
`else
    localparam logic inv = 1'b0;
`endif

    logic [DW-1:0] p2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    logic          m1;
    logic          m2;
    logic [8:0]    err_sum;
    logic [7:0]    err_next;

    // p1 tracks step*sr1; sr2 wraps to register 0 on the last pair, whose pattern is 0
    always_comb begin
        p2       = (bank.sr1 == LAST) ? '0 : p1 + step_q;
        e1       = inv ? ~p1 : p1;
        e2       = inv ? ~p2 : p2;
        m1       = (bank.rdData1 != e1);
        m2       = (bank.rdData2 != e2);
        err_sum  = {1'b0, err_count} + {8'd0, m1} + {8'd0, m2};
        err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            step_q      <= '0;
            p1          <= '0;
            bank.dr     <= '0;
            bank.wrdata <= '0;
            bank.write  <= 1'b0;
            bank.sr1    <= '0;
            bank.sr2    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_addr   <= '0;
`ifdef REGBANK_BIST_INV_PASS_EN
            inv         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        step_q      <= step;
                        err_count   <= '0;
                        pass        <= 1'b0;
                        fail_addr   <= '0;
                        busy        <= 1'b1;
                        bank.write  <= 1'b1;
                        bank.dr     <= '0;
                        bank.wrdata <= '0;
                        state       <= WRITE;
`ifdef REGBANK_BIST_INV_PASS_EN
                        inv         <= 1'b0;
`endif
                    end
                end
                WRITE: begin
                    if (bank.dr == LAST) begin
                        bank.write <= 1'b0;
                        bank.dr    <= '0;
                        bank.sr1   <= '0;
                        bank.sr2   <= AW'(1);
                        p1         <= '0;
                        state      <= READ;
                    end else begin
                        bank.dr     <= bank.dr + AW'(1);
                        // ~(p + step) == ~p - step, so the inverted pattern also accumulates
                        bank.wrdata <= inv ? bank.wrdata - step_q : bank.wrdata + step_q;
                    end
                end
                READ: begin
                    if (m1 || m2) begin
                        err_count <= err_next;
                        if (err_count == 8'd0)
                            fail_addr <= m1 ? bank.sr1 : bank.sr2;
                    end
                    if (bank.sr1 == LAST) begin
                        state    <= FINISH;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= (err_next == 8'd0);
                        bank.sr1 <= '0;
                        bank.sr2 <= '0;
`ifdef REGBANK_BIST_INV_PASS_EN
                        if (!inv) begin
                            inv         <= 1'b1;
                            state       <= WRITE;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            pass        <= 1'b0;
                            bank.write  <= 1'b1;
                            bank.dr     <= '0;
                            bank.wrdata <= '1;
                        end
`endif
                    end else begin
                        bank.sr1 <= bank.sr1 + AW'(1);
                        bank.sr2 <= bank.sr2 + AW'(1);
                        p1       <= p1 + step_q;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regbank_bist.sv
// tb/tb_regbank_bist.sv - randomized self-checking bench for regbank_bist against a bank model
module tb_regbank_bist;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;
`ifdef REGBANK_BIST_INV_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif
    localparam int DONE_EDGE = 2 * NREG * NPASS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] step = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [7:0]    err_count;
    logic [AW-1:0] fail_addr;

    regbank_bist_if #(.DW(DW), .AW(AW)) bif();

    regbank_bist #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .step      (step),
        .bank      (bif.master),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] s0   [NREG];
    logic [DW-1:0] s1   [NREG];
    int wr_count = 0;
    int checks = 0;
    int errors = 0;

    // bank stores written data faithfully; stuck-at faults show up on the read ports only
    always @(posedge clk) begin
        if (bif.write) begin
            regs[bif.dr] <= bif.wrdata;
            wr_count     <= wr_count + 1;
        end
    end
    assign bif.rdData1 = (regs[bif.sr1] & ~s0[bif.sr1]) | s1[bif.sr1];
    assign bif.rdData2 = (regs[bif.sr2] & ~s0[bif.sr2]) | s1[bif.sr2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pattern(input logic [DW-1:0] s, input int k, input int p);
        logic [DW-1:0] v;
        v = s * DW'(k);
        return (p != 0) ? ~v : v;
    endfunction

    task automatic clear_faults();
        for (int i = 0; i < NREG; i++) begin
            s0[i] = '0;
            s1[i] = '0;
        end
    endtask

    task automatic add_fault(input int r, input int b, input int pol);
        if (pol != 0) s1[r][b] = 1'b1;
        else          s0[r][b] = 1'b1;
    endtask

    // expected error count and first failing address from the read order k, (k+1) mod NREG
    task automatic model(input logic [DW-1:0] s, output int e, output int fa);
        logic [DW-1:0] val;
        logic [DW-1:0] rd;
        int a;
        bit found;
        e = 0;
        fa = 0;
        found = 0;
        for (int p = 0; p < NPASS; p++) begin
            for (int k = 0; k < NREG; k++) begin
                for (int j = 0; j < 2; j++) begin
                    a   = (k + j) % NREG;
                    val = pattern(s, a, p);
                    rd  = (val & ~s0[a]) | s1[a];
                    if (rd != val) begin
                        if (!found) begin
                            fa = a;
                            found = 1;
                        end
                        e = (e < 255) ? e + 1 : 255;
                    end
                end
            end
        end
    endtask

    task automatic run(input logic [DW-1:0] s, input bit extra_starts, input string tag);
        int n;
        int first_done;
        int ndone;
        int wr0;
        int e;
        int fa;
        @(negedge clk);
        step  = s;
        start = 1'b1;
        wr0   = wr_count;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ":busy_start"}, busy, 1);
        check({tag, ":write_start"}, bif.write, 1);
        check({tag, ":dr_start"}, bif.dr, 0);
        check({tag, ":wrdata_start"}, bif.wrdata, 0);
        check({tag, ":pass_clr"}, pass, 0);
        n = 0;
        first_done = -1;
        ndone = 0;
        while (n < DONE_EDGE + 10) begin
            start = (extra_starts && (n == 2 || n == 39)) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = n;
            end
        end
        start = 1'b0;
        model(s, e, fa);
        check({tag, ":done_edge"}, first_done, DONE_EDGE);
        check({tag, ":done_count"}, ndone, 1);
        check({tag, ":writes"}, wr_count - wr0, NREG * NPASS);
        check({tag, ":busy_end"}, busy, 0);
        check({tag, ":err_count"}, err_count, e);
        check({tag, ":pass"}, pass, (e == 0));
        check({tag, ":fail_addr"}, fail_addr, fa);
        for (int k = 0; k < NREG; k++)
            check($sformatf("%s:reg%0d", tag, k), regs[k], pattern(s, k, NPASS - 1));
    endtask

    initial begin
        int n;
        int ndone;
        int wr0;
        int e;
        int fa;
        logic [DW-1:0] s;
        clear_faults();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst:write", bif.write, 0);
        check("rst:dr", bif.dr, 0);
        check("rst:wrdata", bif.wrdata, 0);
        check("rst:sr1", bif.sr1, 0);
        check("rst:sr2", bif.sr2, 0);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:pass", pass, 0);
        check("rst:err_count", err_count, 0);
        check("rst:fail_addr", fail_addr, 0);
        @(negedge clk);
        reset = 1'b0;

        run(32'd10, 1'b0, "step10");

        clear_faults();
        add_fault(5, 0, 0);
        run(32'd1, 1'b0, "stuck5");
        repeat (20) @(posedge clk);
        #1;
        model(32'd1, e, fa);
        check("stuck5:err_hold", err_count, e);
        check("stuck5:fa_hold", fail_addr, fa);
        check("stuck5:pass_hold", pass, 0);
        clear_faults();

        run(32'd77, 1'b1, "extra_start");

        run(32'hFFFF_FFFF, 1'b0, "step_ones");
`ifndef REGBANK_BIST_INV_PASS_EN
        check("step_ones:reg31_const", regs[31], 32'hFFFF_FFE1);
`endif

        // reset in the middle of the write phase
        @(negedge clk);
        step  = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst:write", bif.write, 0);
        check("midrst:busy", busy, 0);
        wr0 = wr_count;
        reset = 1'b0;
        ndone = 0;
        n = 0;
        while (n < DONE_EDGE + 10) begin
            @(posedge clk);
            #1;
            n++;
            if (done) ndone++;
        end
        check("midrst:no_done", ndone, 0);
        check("midrst:no_writes", wr_count - wr0, 0);
        run(32'd7, 1'b0, "after_rst");

        // reset and start together
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_start:busy", busy, 0);
        check("rst_start:write", bif.write, 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_start:idle", busy, 0);

        for (int i = 0; i < 6; i++) begin
            int nf;
            clear_faults();
            s  = $urandom;
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++)
                add_fault($urandom_range(0, NREG - 1), $urandom_range(0, DW - 1), $urandom_range(0, 1));
            run(s, 1'b0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
